// File: rtl/umi_regfile_pkg.sv
// Shared types and helpers for the umi_regfile register bank.
// Holds the access FSM state encoding and the address-field width derivations.
// Optional feature macro: UMI_REGFILE_ERR_EN (out-of-range access reporting).
package umi_regfile_pkg;

    // Access FSM states used when wait states are configured
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_e;

    // Number of bytes covered by an access of 2^size bytes
    function automatic int size_to_bytes(input logic [3:0] size);
        return 1 << size;
    endfunction

    // Byte-offset bits within one data word
    function automatic int offset_bits(input int dw);
        return $clog2(dw / 8);
    endfunction

    // Register-index bits for the bank
    function automatic int index_bits(input int nreg);
        return $clog2(nreg);
    endfunction

endpackage

// File: rtl/umi_regfile_strb.sv
// Byte-strobe generator: turns an access size and a byte offset into a
// per-byte enable mask for one DW-bit word. Sizes of a full word or larger
// enable every byte; bytes shifted past the top of the word are dropped.
module umi_regfile_strb
    import umi_regfile_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic [3:0]                                     size,
    input  logic [((offset_bits(DW) > 0) ? offset_bits(DW) : 1)-1:0] off,
    output logic [DW/8-1:0]                                strb
);

    localparam int OB = offset_bits(DW);
    localparam int NB = DW / 8;

    logic [NB-1:0] mask;

    // Unshifted mask: the low 2^size bytes, or the whole word for large sizes
    for (genvar gi = 0; gi < NB; gi++) begin : g_mask
        assign mask[gi] = (int'(size) >= OB) || (gi < size_to_bytes(size));
    end

    // Move the mask up to the addressed byte; overflow bits fall off the top
    assign strb = mask << off;

endmodule

// File: rtl/umi_regfile.sv
// umi_regfile: NREG x DW register bank on the UMI endpoint loc_* interface.
// Byte-granular writes via size/offset strobes, offset-aligned read data,
// optional wait states through a small IDLE/BUSY/ACK FSM, and every register
// exported on regs_out.
// Optional feature macro: UMI_REGFILE_ERR_EN adds the err_addr pulse and a
// sticky miss flag in bit 0 of the last register.
module umi_regfile
    import umi_regfile_pkg::*;
#(
    parameter int              AW     = 64,
    parameter int              DW     = 64,
    parameter int              NREG   = 16,
    parameter logic [AW-1:0]   BASE   = '0,
    parameter int              WAIT   = 0,
    parameter logic [DW-1:0]   RSTVAL = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [AW-1:0]        loc_addr,
    input  logic                 loc_write,
    input  logic                 loc_read,
    input  logic [3:0]           loc_size,
    input  logic [DW-1:0]        loc_wrdata,
    output logic [DW-1:0]        loc_rddata,
    output logic                 loc_ready,
    output logic [NREG*DW-1:0]   regs_out
`ifdef UMI_REGFILE_ERR_EN
    ,
    output logic                 err_addr
`endif
);

    localparam int OB  = offset_bits(DW);
    localparam int IB  = index_bits(NREG);
    localparam int NB  = DW / 8;
    localparam int OBW = (OB > 0) ? OB : 1;

    logic [DW-1:0]  regs_reg [NREG];
    logic [IB-1:0]  idx;
    logic [OBW-1:0] off;
    logic           hit;
    logic           req;
    logic           wr_commit;
    logic [NB-1:0]  strb;
    logic [DW-1:0]  bit_mask;
    logic [DW-1:0]  wr_merged;
    logic [DW-1:0]  rd_decoded;

    // Address decode: index, byte offset and bank hit
    assign idx = loc_addr[OB+IB-1:OB];
    if (OB > 0) begin : g_off
        assign off = loc_addr[OB-1:0];
    end else begin : g_no_off
        assign off = '0;
    end
    assign hit = (loc_addr[AW-1:OB+IB] == BASE[AW-1:OB+IB]);
    assign req = loc_read | loc_write;

    umi_regfile_strb #(
        .DW (DW)
    ) u_strb (
        .size (loc_size),
        .off  (off),
        .strb (strb)
    );

    // Expand byte strobes to a bit mask for the read-modify-write merge
    for (genvar gi = 0; gi < NB; gi++) begin : g_bit_mask
        assign bit_mask[gi*8 +: 8] = {8{strb[gi]}};
    end

    assign wr_merged  = (regs_reg[idx] & ~bit_mask) | (loc_wrdata & bit_mask);
    assign rd_decoded = hit ? (regs_reg[idx] >> (8 * off)) : '0;

    if (WAIT == 0) begin : g_nowait
        // Single-cycle: always ready outside reset, data straight from the bank
        assign loc_ready  = ~reset;
        assign loc_rddata = rd_decoded;
        assign wr_commit  = loc_write & hit & ~reset;
    end else begin : g_wait
        localparam int CW = (WAIT > 1) ? $clog2(WAIT) : 1;

        state_e         state_reg;
        logic [CW-1:0]  cnt_reg;
        logic [DW-1:0]  rddata_reg;

        // Wait-state FSM: count down in BUSY, capture read data, ack for one cycle
        always_ff @(posedge clk) begin
            if (reset) begin
                state_reg  <= IDLE;
                cnt_reg    <= '0;
                rddata_reg <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (req) begin
                            cnt_reg   <= CW'(WAIT - 1);
                            state_reg <= BUSY;
                        end
                    end
                    BUSY: begin
                        if (!req) begin
                            state_reg <= IDLE;
                        end else if (cnt_reg == '0) begin
                            rddata_reg <= rd_decoded;
                            state_reg  <= ACK;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                    ACK:     state_reg <= IDLE;
                    default: state_reg <= IDLE;
                endcase
            end
        end

        // The write lands only on the acknowledging edge, so an abandoned
        // request never disturbs the bank
        assign loc_ready  = (state_reg == ACK) & ~reset;
        assign loc_rddata = rddata_reg;
        assign wr_commit  = loc_ready & loc_write & hit;
    end

`ifdef UMI_REGFILE_ERR_EN
    logic miss_done;
    assign miss_done = loc_ready & req & ~hit;
    assign err_addr  = miss_done;
`endif

    // Register bank: reset to RSTVAL, byte-masked writes, sticky miss flag
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                regs_reg[r] <= RSTVAL;
            end
        end else begin
            if (wr_commit) begin
                regs_reg[idx] <= wr_merged;
            end
`ifdef UMI_REGFILE_ERR_EN
            if (wr_commit && (idx == IB'(NREG - 1))) begin
                regs_reg[NREG-1][0] <= 1'b0;
            end else if (miss_done) begin
                regs_reg[NREG-1][0] <= 1'b1;
            end
`endif
        end
    end

    // Flatten the bank for hardware consumers
    for (genvar gi = 0; gi < NREG; gi++) begin : g_regs_out
        assign regs_out[gi*DW +: DW] = regs_reg[gi];
    end

endmodule
